mvu_result_reader: RTL and testbench
====================================

Name: mvu_result_reader

Overview:
- Downstream counterpart of the MVU input data transposer.
- Reads bit-serial (bit-plane) results from the MVU output RAM and re-assembles one XLEN-bit word per lane.
- Streams the words to the PITO/host side over a valid/ready interface.
- Sits between the mvutop read port and the accelerator-side result consumer (PITO load path or DMA).

Parameters:
- NUM_WORDS, 64, number of lanes per RAM line; must equal MVU_DATA_LEN.
- XLEN, 32, output word width.
- MVU_ADDR_LEN, 15, MVU RAM address width.
- MVU_DATA_LEN, 64, MVU RAM data width (1 bit per lane).
- MAX_DATA_PREC, 16, maximum supported precision; must be ≤ XLEN.
- RD_LAT, 2, fixed MVU RAM read latency in cycles; must be ≥ 1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  job request pulse
- prec  input  32  bits per value P, sampled at accepted start
- baddr  input  32  base RAM address; low MVU_ADDR_LEN bits used
- signed_en  input  1  sign-extend output words, sampled at start
- busy  output  1  job in progress
- done  output  1  one-cycle pulse after last word handshake
- err  output  1  one-cycle pulse on rejected start
- mvu_rd_en  output  1  RAM read enable
- mvu_rd_addr  output  MVU_ADDR_LEN  RAM read address
- mvu_rd_word  input  MVU_DATA_LEN  RAM read data, valid RD_LAT cycles after mvu_rd_en
- oword  output  XLEN  reassembled word
- ovalid  output  1  oword valid
- oready  input  1  consumer ready
- olast  output  1  marks word NUM_WORDS-1

Behaviour:
- Reset values: all outputs 0. FSM returns to IDLE; lane accumulators, counters and read-latency pipeline clear. Reset mid-job abandons the job with no done and no err, and in-flight RAM data is discarded.
- Start acceptance:
  - start is accepted only in IDLE (busy=0). start while busy is ignored with no err.
  - If prec==0 or prec>MAX_DATA_PREC, start is rejected: err=1 for one cycle, state stays IDLE, no RAM reads.
- States: IDLE -> READ -> DRAIN -> EMIT -> IDLE.
- IDLE:
  - On an accepted start at cycle T: latch P, baddr and signed_en; busy=1 from T+1.
- READ:
  - Cycles T+1..T+P: mvu_rd_en=1, mvu_rd_addr=baddr+k for k=0..P-1.
  - Address addition is modulo 2^MVU_ADDR_LEN (wraps).
  - After P reads, go to DRAIN.
- Plane mapping:
  - Line baddr+k holds bit (P-1-k) of every lane, i.e. MSB plane first.
  - Lane i bit is mvu_rd_word[i].
- Capture:
  - A RD_LAT-deep valid shift register tracks outstanding reads.
  - Each returning line does acc[i] <= {acc[i][MAX_DATA_PREC-2:0], mvu_rd_word[i]} for every lane i.
- DRAIN: wait until all P lines have returned; the last arrives at T+P+RD_LAT. Then go to EMIT.
- EMIT:
  - ovalid=1 from T+P+RD_LAT+1. The word index starts at 0.
  - oword = acc[idx][P-1:0], zero-extended to XLEN when signed_en=0, sign-extended from bit P-1 when signed_en=1.
  - oword, olast and ovalid stay stable while ovalid=1 and oready=0.
  - Index advances on ovalid&oready; back-to-back transfers give one word per cycle.
  - olast=1 when idx==NUM_WORDS-1.
  - On the handshake of the last word: next cycle ovalid=0, busy=0, done=1 for one cycle, state IDLE.
- start in the done cycle is accepted normally.
- oready is ignored outside EMIT. mvu_rd_word is ignored when no read is outstanding.
- Throughput: one job = P + RD_LAT + 1 + NUM_WORDS cycles minimum (oready held 1).

Test Plan:
- Basic unsigned: P=2, baddr=0x10, RAM[0x10]=all-ones, RAM[0x11]=0x5555…5555, signed_en=0, oready=1.
  - Reads at 0x10 then 0x11.
  - Lane 0 (bits 1,1) gives oword=3; lane 1 (bits 1,0) gives oword=2.
  - Alternating 3,2 for 64 words, olast on word 63, done one cycle later.
- Signed: P=4, all four planes all-ones, signed_en=1.
  - Every oword=0xFFFFFFFF.
  - Repeating with signed_en=0 gives 0x0000000F.
- Backpressure: oready toggles 1,0,0,1 randomly during EMIT.
  - oword/olast stay stable while stalled.
  - Exactly 64 handshakes in lane order, no word lost or duplicated.
- Address wrap: baddr=0x7FFF, P=3.
  - mvu_rd_addr sequence 0x7FFF, 0x0000, 0x0001.
  - Values assembled correctly.
- Invalid/overlap:
  - prec=0 and prec=17 each give err=1 for one cycle, no mvu_rd_en, busy stays 0.
  - start pulsed during a valid job is ignored, and the job completes unchanged.
- Reset mid-job: assert rst during DRAIN.
  - All outputs 0 immediately, no done.
  - A following job with P=1 completes correctly with no stale data from the aborted job.

Source files
------------

// File: rtl/mvu_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : mvu_result_reader
// Brief    : Reads MSB-first bit-plane lines from the MVU RAM and streams one
//            re-assembled XLEN-bit word per lane over valid/ready.
// Revision : 1.0
// ============================================================================
module mvu_result_reader #(
  parameter int NUM_WORDS     = 64,
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MVU_DATA_LEN  = 64,
  parameter int MAX_DATA_PREC = 16,
  parameter int RD_LAT        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             prec,
  input  logic [31:0]             baddr,
  input  logic                    signed_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    mvu_rd_en,
  output logic [MVU_ADDR_LEN-1:0] mvu_rd_addr,
  input  logic [MVU_DATA_LEN-1:0] mvu_rd_word,
  output logic [XLEN-1:0]         oword,
  output logic                    ovalid,
  input  logic                    oready,
  output logic                    olast
);

  localparam int c_prec_w = $clog2(MAX_DATA_PREC + 1);
  localparam int c_idx_w  = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_prec_w-1:0]       r_prec;
  logic [MVU_ADDR_LEN-1:0]   r_base;
  logic                      r_signed;
  logic [c_prec_w-1:0]       r_rd_cnt;
  logic [c_prec_w-1:0]       r_ret_cnt;
  logic [RD_LAT-1:0]         r_vld;
  logic [c_idx_w-1:0]        r_idx;
  logic                      r_done;
  logic                      r_err;
  logic [MAX_DATA_PREC-1:0]  w_acc [NUM_WORDS];

  logic                      w_prec_ok;
  logic                      w_accept;
  logic                      w_capture;
  logic                      w_last_rd;
  logic                      w_last_ret;
  logic                      w_last_word;
  logic                      w_hs;
  logic [MAX_DATA_PREC-1:0]  w_sel;
  logic [MAX_DATA_PREC-1:0]  w_sign_sel;
  logic [XLEN-1:0]           w_mask;
  logic [XLEN-1:0]           w_val;
  logic                      w_neg;
  logic                      w_unused;

  assign w_unused    = ^baddr[31:MVU_ADDR_LEN];
  assign w_prec_ok   = (prec != 32'd0) && (prec <= 32'(MAX_DATA_PREC));
  assign w_accept    = (r_state == S_IDLE) && start && w_prec_ok;
  assign w_capture   = r_vld[RD_LAT-1];
  assign w_last_rd   = (r_rd_cnt == r_prec - c_prec_w'(1));
  assign w_last_ret  = w_capture && (r_ret_cnt == r_prec - c_prec_w'(1));
  assign w_last_word = (r_idx == c_idx_w'(NUM_WORDS - 1));
  assign w_hs        = ovalid && oready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    mvu_rd_en   = 1'b0;
    ovalid      = 1'b0;
    olast       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_READ;
      end
      S_READ: begin
        busy      = 1'b1;
        mvu_rd_en = 1'b1;
        if (w_last_rd) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_last_ret) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        busy   = 1'b1;
        ovalid = 1'b1;
        olast  = w_last_word;
        if (oready && w_last_word) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prec    <= '0;
      r_base    <= '0;
      r_signed  <= 1'b0;
      r_rd_cnt  <= '0;
      r_ret_cnt <= '0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_hs && w_last_word;
      r_err  <= (r_state == S_IDLE) && start && !w_prec_ok;
      if (w_accept) begin
        r_prec    <= prec[c_prec_w-1:0];
        r_base    <= baddr[MVU_ADDR_LEN-1:0];
        r_signed  <= signed_en;
        r_rd_cnt  <= '0;
        r_ret_cnt <= '0;
        r_idx     <= '0;
      end
      if (mvu_rd_en) r_rd_cnt  <= r_rd_cnt + c_prec_w'(1);
      if (w_capture) r_ret_cnt <= r_ret_cnt + c_prec_w'(1);
      if (w_hs)      r_idx     <= r_idx + c_idx_w'(1);
    end
  end

  // Each bit marks a read still in flight; the top bit lines up with returning data.
  if (RD_LAT == 1) begin : g_vld_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vld <= '0;
      else     r_vld <= mvu_rd_en;
    end
  end else begin : g_vld_shift
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vld <= '0;
      else     r_vld <= {r_vld[RD_LAT-2:0], mvu_rd_en};
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_lane
    logic [MAX_DATA_PREC-1:0] r_acc;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_acc <= '0;
      else if (w_capture) r_acc <= {r_acc[MAX_DATA_PREC-2:0], mvu_rd_word[g]};
    end
    assign w_acc[g] = r_acc;
  end

  assign mvu_rd_addr = mvu_rd_en ? (r_base + MVU_ADDR_LEN'(r_rd_cnt)) : '0;

  // Stale bits above P remain in the accumulator; masking keeps only the job's planes.
  assign w_sel      = w_acc[r_idx];
  assign w_mask     = ~({XLEN{1'b1}} << r_prec);
  assign w_val      = XLEN'(w_sel) & w_mask;
  assign w_sign_sel = MAX_DATA_PREC'(1) << (r_prec - c_prec_w'(1));
  assign w_neg      = r_signed && (|(w_sel & w_sign_sel));
  assign oword      = ovalid ? (w_neg ? (w_val | ~w_mask) : w_val) : '0;

  assign done = r_done;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mvu_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvu_result_reader
// Brief    : Directed bench for mvu_result_reader with a bit-plane RAM model.
// Revision : 1.0
// ============================================================================
module tb_mvu_result_reader;

  localparam int RD_LAT = 2;
  localparam int NW     = 64;

  logic        clk, rst, start, signed_en, oready;
  logic [31:0] prec, baddr;
  logic        busy, done, err, mvu_rd_en, ovalid, olast;
  logic [14:0] mvu_rd_addr;
  logic [63:0] mvu_rd_word;
  logic [31:0] oword;

  mvu_result_reader #(
    .NUM_WORDS(NW), .XLEN(32), .MVU_ADDR_LEN(15), .MVU_DATA_LEN(64),
    .MAX_DATA_PREC(16), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .prec(prec), .baddr(baddr),
    .signed_en(signed_en), .busy(busy), .done(done), .err(err),
    .mvu_rd_en(mvu_rd_en), .mvu_rd_addr(mvu_rd_addr), .mvu_rd_word(mvu_rd_word),
    .oword(oword), .ovalid(ovalid), .oready(oready), .olast(olast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: fixed latency, garbage returned for cycles without a read.
  logic [63:0] mem [0:32767];
  logic [63:0] rq  [RD_LAT];
  always @(posedge clk) begin
    rq[0] <= mvu_rd_en ? mem[mvu_rd_addr] : {$urandom, $urandom};
    for (int j = 1; j < RD_LAT; j++) rq[j] <= rq[j-1];
  end
  assign mvu_rd_word = rq[RD_LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job model: expected addresses and words straight from the plane layout.
  logic [14:0] exp_addr [16];
  logic [31:0] exp_word [NW];
  int m_p, m_rd, m_idx;

  task automatic setup_model(input int p, input logic [31:0] base, input logic sgn);
    logic [31:0] v, msk;
    logic [14:0] a;
    m_p = p; m_rd = 0; m_idx = 0;
    for (int k = 0; k < p; k++) exp_addr[k] = 15'(base + 32'(k));
    msk = (32'd1 << p) - 32'd1;
    for (int i = 0; i < NW; i++) begin
      v = 0;
      for (int k = 0; k < p; k++) begin
        a = 15'(base + 32'(k));
        if (mem[a][i]) v = v + (32'd1 << (p - 1 - k));
      end
      if (sgn && v[p-1]) v = v | ~msk;
      exp_word[i] = v;
    end
  endtask

  // Cycle-by-cycle compare against the model.
  logic        prev_v, prev_r, prev_l;
  logic [31:0] prev_w;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (mvu_rd_en) begin
        if (m_rd < m_p) chk("rd_addr", 64'(mvu_rd_addr), 64'(exp_addr[m_rd]));
        else            chk("extra_read", 64'(m_rd), 64'(m_p));
        m_rd++;
      end
      if (prev_v && !prev_r) begin
        chk("stall_valid", 64'(ovalid), 64'd1);
        chk("stall_word", 64'(oword), 64'(prev_w));
        chk("stall_last", 64'(olast), 64'(prev_l));
      end
      if (ovalid) begin
        if (m_idx < NW) begin
          chk("oword", 64'(oword), 64'(exp_word[m_idx]));
          chk("olast", 64'(olast), 64'(m_idx == NW - 1));
        end else begin
          chk("extra_word", 64'(m_idx), 64'(NW - 1));
        end
        if (oready) m_idx++;
      end
      if (done) chk("done_after_last", 64'(m_idx), 64'(NW));
      prev_v = ovalid; prev_r = oready; prev_w = oword; prev_l = olast;
    end
  end

  task automatic chk_zero(input string name);
    chk(name, 64'({busy, done, err, mvu_rd_en, mvu_rd_addr, oword, ovalid, olast}), 64'd0);
  endtask

  task automatic run_job(input int p, input logic [31:0] base, input logic sgn,
                         input bit bp, input bit ovl);
    setup_model(p, base, sgn);
    @(posedge clk); #1;
    start = 1; prec = p; baddr = base; signed_en = sgn; oready = !bp;
    @(posedge clk); #1;
    start = 0;
    for (int n = 1; n <= p + RD_LAT + 1; n++) begin
      #2;
      chk("busy", 64'(busy), 64'd1);
      chk("err_quiet", 64'(err), 64'd0);
      chk("rd_en", 64'(mvu_rd_en), 64'(n <= p));
      chk("ovalid_timing", 64'(ovalid), 64'(n == p + RD_LAT + 1));
      if (ovl && n == 2) begin
        start = 1; prec = 7; baddr = 32'h123; signed_en = !sgn;
      end else begin
        start = 0;
      end
      @(posedge clk); #1;
      if (bp) oready = 1'($urandom_range(0, 1));
    end
    start = 0;
    for (int c = 0; c < 4000 && m_idx < NW; c++) begin
      @(posedge clk); #1;
      oready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("word_count", 64'(m_idx), 64'(NW));
    #1;
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("ovalid_end", 64'(ovalid), 64'd0);
    @(posedge clk); #2;
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic reject(input int p);
    @(posedge clk); #1;
    start = 1; prec = p; baddr = 32'h10;
    @(posedge clk); #1;
    start = 0;
    #1;
    chk("rej_err", 64'(err), 64'd1);
    chk("rej_busy", 64'(busy), 64'd0);
    chk("rej_rd", 64'(mvu_rd_en), 64'd0);
    @(posedge clk); #2;
    chk("rej_err_pulse", 64'(err), 64'd0);
    chk("rej_idle", 64'({busy, mvu_rd_en}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; prec = 0; baddr = 0; signed_en = 0; oready = 0;
    m_p = 0; m_rd = 0; m_idx = 0;
    for (int a = 0; a < 32768; a++) mem[a] = 64'd0;
    repeat (2) @(posedge clk);
    #2 chk_zero("reset_outputs");
    @(posedge clk); #1 rst = 0;

    // Basic unsigned, P=2
    mem[15'h10] = '1;
    mem[15'h11] = 64'h5555_5555_5555_5555;
    run_job(2, 32'h10, 1'b0, 1'b0, 1'b0);
    chk("model_lane0", 64'(exp_word[0]), 64'd3);
    chk("model_lane1", 64'(exp_word[1]), 64'd2);

    // Signed and unsigned all-ones, P=4
    for (int k = 0; k < 4; k++) mem[15'h20 + 15'(k)] = '1;
    run_job(4, 32'h20, 1'b1, 1'b0, 1'b0);
    chk("model_signed", 64'(exp_word[7]), 64'hFFFF_FFFF);
    run_job(4, 32'h20, 1'b0, 1'b0, 1'b0);
    chk("model_unsigned", 64'(exp_word[7]), 64'hF);

    // Backpressure, random data
    for (int k = 0; k < 5; k++) mem[15'h40 + 15'(k)] = {$urandom, $urandom};
    run_job(5, 32'h40, 1'b0, 1'b1, 1'b0);

    // Address wrap
    mem[15'h7FFF] = {$urandom, $urandom};
    mem[15'h0000] = {$urandom, $urandom};
    mem[15'h0001] = {$urandom, $urandom};
    run_job(3, 32'h7FFF, 1'b1, 1'b0, 1'b0);
    chk("model_wrap_addr", 64'(exp_addr[1]), 64'h0);

    // Maximum precision, signed, with backpressure
    for (int k = 0; k < 16; k++) mem[15'h100 + 15'(k)] = {$urandom, $urandom};
    run_job(16, 32'h100, 1'b1, 1'b1, 1'b0);

    // Rejected starts and overlapping start
    reject(0);
    reject(17);
    run_job(2, 32'h10, 1'b0, 1'b0, 1'b1);

    // Reset during DRAIN
    for (int k = 0; k < 4; k++) mem[15'h200 + 15'(k)] = {$urandom, $urandom};
    setup_model(4, 32'h200, 1'b0);
    @(posedge clk); #1;
    start = 1; prec = 4; baddr = 32'h200; signed_en = 0; oready = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1 chk("in_drain", 64'({busy, mvu_rd_en, ovalid}), 64'b100);
    #1 rst = 1;
    #1 chk_zero("rst_midjob");
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      chk("no_done_after_rst", 64'({done, busy, ovalid}), 64'd0);
    end
    mem[15'h300] = {$urandom, $urandom};
    run_job(1, 32'h300, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
